// File: rtl/addsub_share_arbiter.sv
// Two-requester round-robin arbiter in front of one shared ripple add/subtract datapath.
// The FSM runs IDLE -> EXEC -> RESP, so there is one operation in flight at a time.

module addsub_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module addsub_share_arbiter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_s,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
  } op_t;

  logic [1:0]       state;
  op_t              op_q;
  logic             owner;
  logic             last_grant;
  logic             grant0, grant1;
  logic [WIDTH-1:0] bx, sum;
  logic [WIDTH:0]   c;

  // Requester 1 wins when it is alone or when requester 0 was served last.
  assign grant1 = req1_valid && (!req0_valid || !last_grant);
  assign grant0 = req0_valid && !grant1;

  // Gated by rst_n so every output reads 0 while reset is held.
  assign req0_ready = rst_n && (state == IDLE) && grant0;
  assign req1_ready = rst_n && (state == IDLE) && grant1;
  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) && owner;
  assign busy       = (state != IDLE);

  // Subtract is A + ~B + 1: the sub bit inverts B and feeds the carry-in.
  assign bx   = op_q.b ^ {WIDTH{op_q.sub}};
  assign c[0] = op_q.sub;

  addsub_fa u_fa [WIDTH-1:0] (
    .a  (op_q.a),
    .b  (bx),
    .ci (c[WIDTH-1:0]),
    .s  (sum),
    .co (c[WIDTH:1])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      rsp_s      <= '0;
      rsp_cout   <= 1'b0;
      rsp_ovf    <= 1'b0;
      ops_done   <= '0;
    end else begin
      case (state)
        IDLE: if (req0_ready || req1_ready) begin
          op_q       <= grant1 ? {req1_a, req1_b, req1_sub} : {req0_a, req0_b, req0_sub};
          owner      <= grant1;
          last_grant <= grant1;
          state      <= EXEC;
        end
        EXEC: begin
          rsp_s    <= sum;
          rsp_cout <= c[WIDTH];
          rsp_ovf  <= c[WIDTH] ^ c[WIDTH-1];
          state    <= RESP;
        end
        RESP: if (owner ? rsp1_ready : rsp0_ready) begin
          ops_done <= ops_done + CNT_W'(1);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_share_arbiter.sv
// Bench for addsub_share_arbiter: cycle-level reference of the request/response protocol
// with arithmetic computed from integer math, plus directed literal checks.

module tb_addsub_share_arbiter;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, req0_sub = 1'b0, req1_sub = 1'b0;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_cout, rsp_ovf, busy;
  logic [15:0] rsp_s, ops_done;

  int errors = 0, checks = 0;
  int pcyc = 0;
  bit rnd_rsp = 1'b0;
  int gq[$];

  addsub_share_arbiter #(.WIDTH(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sub(req0_sub), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sub(req1_sub), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_s(rsp_s), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pcyc <= pcyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, pcyc);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting (cycle %0d)", nm, pcyc);
  endtask

  // Integer-arithmetic reference for one operation.
  function automatic void golden(input logic [15:0] a, input logic [15:0] b, input logic sub,
                                 output logic [15:0] s, output logic c, output logic o);
    int ua, ub, sa, sb, r;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    if (sub) begin
      r = sa - sb; s = 16'(ua - ub); c = (ua >= ub);
    end else begin
      r = sa + sb; s = 16'(ua + ub); c = (ua + ub) > 65535;
    end
    o = (r > 32767) || (r < -32768);
  endfunction

  // Reference: m_t is the cycle an operation was accepted (-1 when idle).
  int          m_t = -1;
  logic        m_own = 1'b0, m_last = 1'b1;
  logic [15:0] m_ops = '0, m_s = '0, p_s = '0;
  logic        m_c = 1'b0, m_o = 1'b0, p_c = 1'b0, p_o = 1'b0;
  logic        m_idle, m_g0, m_g1, m_rsp;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy,
                            rsp_cout, rsp_ovf, rsp_s, ops_done}, 64'd0);
      m_t = -1; m_last = 1'b1; m_ops = '0; m_s = '0; m_c = 1'b0; m_o = 1'b0;
    end else begin
      m_idle = (m_t < 0);
      m_g1   = req1_valid && (!req0_valid || !m_last);
      m_g0   = req0_valid && !m_g1;
      m_rsp  = !m_idle && (pcyc >= m_t + 2);
      chk("req0_ready", req0_ready, m_idle && m_g0);
      chk("req1_ready", req1_ready, m_idle && m_g1);
      chk("rsp0_valid", rsp0_valid, m_rsp && !m_own);
      chk("rsp1_valid", rsp1_valid, m_rsp && m_own);
      chk("busy", busy, !m_idle);
      chk("rsp_s", rsp_s, m_s);
      chk("rsp_cout", rsp_cout, m_c);
      chk("rsp_ovf", rsp_ovf, m_o);
      chk("ops_done", ops_done, m_ops);
      if (!m_idle && pcyc == m_t + 1) begin
        m_s = p_s; m_c = p_c; m_o = p_o;
      end
      if (m_idle && (m_g0 || m_g1)) begin
        m_t = pcyc; m_own = m_g1; m_last = m_g1;
        if (m_g1) golden(req1_a, req1_b, req1_sub, p_s, p_c, p_o);
        else      golden(req0_a, req0_b, req0_sub, p_s, p_c, p_o);
      end else if (m_rsp && (m_own ? rsp1_ready : rsp0_ready)) begin
        m_ops = m_ops + 16'd1;
        m_t = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && req0_ready) gq.push_back(0);
    if (rst_n && req1_ready) gq.push_back(1);
  end

  always @(posedge clk) if (rnd_rsp) begin
    #1;
    rsp0_ready = 1'($urandom_range(0, 1));
    rsp1_ready = 1'($urandom_range(0, 1));
  end

  task automatic set_req(input int id, input logic v, input logic [15:0] a,
                         input logic [15:0] b, input logic sub);
    if (id == 0) begin req0_valid = v; req0_a = a; req0_b = b; req0_sub = sub; end
    else         begin req1_valid = v; req1_a = a; req1_b = b; req1_sub = sub; end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, output int hs);
    hs = -1;
    set_req(id, 1'b1, a, b, sub);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (id == 0 ? req0_ready : req1_ready) begin hs = pcyc; break; end
    end
    if (hs < 0) timeout("issue");
    @(posedge clk); #1;
    set_req(id, 1'b0, a, b, sub);
  endtask

  task automatic take_rsp(input int id, input int hold, output logic [15:0] s,
                          output logic c, output logic o, output int vc);
    vc = -1; s = '0; c = 1'b0; o = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (id == 0 ? rsp0_valid : rsp1_valid) begin vc = pcyc; break; end
    end
    if (vc < 0) timeout("rsp_wait");
    s = rsp_s; c = rsp_cout; o = rsp_ovf;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_rsp_s", rsp_s, s);
      chk("hold_other_ready", id == 0 ? req1_ready : req0_ready, 1'b0);
    end
    @(posedge clk); #1;
    if (id == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    @(posedge clk); #1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("wait_idle");
    @(posedge clk); #1;
  endtask

  task automatic rnd_driver(input int id, input int n);
    int hs;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      if ($urandom_range(0, 9) == 0) begin
        set_req(id, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
        @(posedge clk); #1;
        set_req(id, 1'b0, 16'h0, 16'h0, 1'b0);
      end else begin
        issue(id, 16'($urandom), 16'($urandom), 1'($urandom), hs);
      end
    end
  endtask

  logic [15:0] ba[4] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0005};
  logic [15:0] bb[4] = '{16'h0001, 16'h0001, 16'h0001, 16'h0005};
  logic        bs[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [15:0] es[4] = '{16'h8000, 16'h7FFF, 16'h0000, 16'h0000};
  logic        ec[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  logic        eo[4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int hs, vc;
    logic [15:0] s;
    logic c, o;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Requester 0 alone, 12 - 24
    issue(0, 16'd12, 16'd24, 1'b1, hs);
    take_rsp(0, 0, s, c, o, vc);
    chk("t1_s", s, 16'hFFF4);
    chk("t1_cout", c, 1'b0);
    chk("t1_ovf", o, 1'b0);
    chk("t1_latency", vc - hs, 2);
    @(negedge clk);
    chk("t1_ops_done", ops_done, 16'd1);
    @(posedge clk); #1;

    // Requester 1 alone, 17557 + 2652
    issue(1, 16'd17557, 16'd2652, 1'b0, hs);
    take_rsp(1, 0, s, c, o, vc);
    chk("t2_s", s, 16'h4EF1);
    chk("t2_cout", c, 1'b0);
    chk("t2_ovf", o, 1'b0);

    // Both always valid from reset: alternating grants
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    gq.delete();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    fork
      begin issue(0, 16'd1, 16'd2, 1'b0, hs); issue(0, 16'd3, 16'd4, 1'b0, hs); end
      begin issue(1, 16'd5, 16'd6, 1'b1, vc); issue(1, 16'd7, 16'd8, 1'b1, vc); end
    join
    wait_idle();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    chk("t3_grant_count", gq.size(), 4);
    if (gq.size() == 4) begin
      chk("t3_grant0", gq[0], 0);
      chk("t3_grant1", gq[1], 1);
      chk("t3_grant2", gq[2], 0);
      chk("t3_grant3", gq[3], 1);
    end

    // Boundary arithmetic
    for (int i = 0; i < 4; i++) begin
      issue(0, ba[i], bb[i], bs[i], hs);
      take_rsp(0, 0, s, c, o, vc);
      chk("t4_s", s, es[i]);
      chk("t4_cout", c, ec[i]);
      chk("t4_ovf", o, eo[i]);
    end

    // Response backpressure with requester 1 waiting
    issue(0, 16'd100, 16'd50, 1'b1, hs);
    set_req(1, 1'b1, 16'd3, 16'd4, 1'b0);
    take_rsp(0, 5, s, c, o, vc);
    chk("t5_s", s, 16'd50);
    @(negedge clk);
    chk("t5_req1_granted", req1_ready, 1'b1);
    @(posedge clk); #1;
    set_req(1, 1'b0, 16'd3, 16'd4, 1'b0);
    take_rsp(1, 0, s, c, o, vc);
    chk("t5_req1_s", s, 16'd7);

    // Reset during EXEC, then simultaneous request
    issue(0, 16'd1, 16'd2, 1'b0, hs);
    rst_n = 1'b0;
    #1;
    chk("t6_abort_outputs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy,
                             rsp_cout, rsp_ovf, rsp_s, ops_done}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    set_req(0, 1'b1, 16'd9, 16'd1, 1'b0);
    set_req(1, 1'b1, 16'd2, 16'd2, 1'b1);
    @(negedge clk);
    chk("t6_req0_wins", req0_ready, 1'b1);
    chk("t6_req1_waits", req1_ready, 1'b0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 16'd0, 16'd0, 1'b0);
    take_rsp(0, 0, s, c, o, vc);
    chk("t6_s0", s, 16'd10);
    issue(1, 16'd2, 16'd2, 1'b1, hs);
    take_rsp(1, 0, s, c, o, vc);
    chk("t6_s1", s, 16'd0);
    chk("t6_cout1", c, 1'b1);

    // Randomized traffic with random response backpressure
    rnd_rsp = 1'b1;
    fork
      rnd_driver(0, 150);
      rnd_driver(1, 150);
    join
    wait_idle();
    rnd_rsp = 1'b0;
    @(posedge clk); #1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", pcyc);
    $fatal(1);
  end

endmodule

// File: doc/addsub_share_arbiter.md
Name: addsub_share_arbiter

Overview:
- Shares one 16-bit add/subtract datapath between two requesters.
- The datapath is a ripple adder with XOR-inverted B operand and carry-in used as the subtract select.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The block arbitrates round-robin, sequences one operation at a time through a 3-state FSM, registers the result and flags, and holds each response until the owner accepts it.

Parameters:
- WIDTH, 16, operand/result width; the datapath is sized to this.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  WIDTH  operand A.
- req0_b  in  WIDTH  operand B.
- req0_sub  in  1  0 = A+B, 1 = A-B.
- rsp0_valid  out  1  result for requester 0 is available.
- rsp0_ready  in  1  requester 0 accepts the result.
- req1_valid, req1_ready, req1_a, req1_b, req1_sub  same as above, for requester 1.
- rsp1_valid, rsp1_ready  same as above, for requester 1.
- rsp_s  out  WIDTH  registered result, shared by both response channels.
- rsp_cout  out  1  carry out of the MSB; for subtract, 1 = no borrow.
- rsp_ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.
- busy  out  1  FSM not in IDLE.
- ops_done  out  CNT_W  count of completed response handshakes; wraps.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, all outputs 0.
  - last_grant=1, so requester 0 wins the first tie.
  - Captured operands cleared.
- IDLE:
  - req_ready is combinational: only the granted requester sees ready=1, and only while its valid=1.
  - Only one valid: grant it. Both valid: grant the requester that is not last_grant.
  - On handshake: latch a, b, sub and owner; set last_grant=owner; go to EXEC.
- EXEC (1 cycle):
  - Datapath computes A + (B XOR {WIDTH{sub}}) + sub.
  - Register rsp_s, rsp_cout, rsp_ovf; go to RESP.
- RESP:
  - rsp<owner>_valid=1; the other rsp_valid stays 0.
  - rsp_s and flags stay stable while valid and not ready.
  - On rsp<owner>_ready=1: increment ops_done and go to IDLE. No new grant in this cycle.
  - Throughput: at most 1 operation per 3 cycles; request-to-rsp_valid latency is 2 cycles.
- Requester rules:
  - Must hold valid, a, b and sub stable until ready.
  - Valid deasserted before ready drops the request; nothing is latched.
- Backpressure: all req_ready stay 0 outside IDLE, and req_ready stays 0 while the owner's response is pending.
- Arithmetic: modulo 2^WIDTH. Flags come from the same addition, so cout and ovf are valid for both add and subtract.
- ops_done wraps from 2^CNT_W-1 to 0 with no saturation.
- Reset asserted mid-operation: abort immediately; the pending result is lost and all outputs go to reset values.
- The rsp_ready of the non-owner requester is ignored.

Test Plan:
- Req0 only, sub=1, a=12, b=24 -> rsp0_valid 2 cycles after handshake; rsp_s=0xFFF4, cout=0, ovf=0; ops_done=1.
- Req1 only, add, a=17557, b=2652 -> rsp_s=0x4EF1 (20209), cout=0, ovf=0; rsp0_valid never asserts.
- Both valid continuously for 4 ops, starting from reset -> grant order 0,1,0,1; each req_ready pulses once per 3+ cycles.
- Boundary values, one per op:
  - 0x7FFF+1 -> 0x8000, ovf=1, cout=0.
  - 0x8000-1 -> 0x7FFF, ovf=1, cout=1.
  - 0xFFFF+1 -> 0x0000, cout=1, ovf=0.
  - 5-5 -> 0x0000, cout=1, ovf=0.
- Hold rsp0_ready=0 for 5 cycles in RESP, with req1_valid=1 -> rsp_s stable, req1_ready=0 throughout; on release, req1 is granted next IDLE cycle.
- Drop rst_n during EXEC -> all outputs 0 immediately; after release, req0 wins a simultaneous request.
